// File: rtl/mul_div.sv
// Iterative multiply/divide unit: MUL, MULH, DIV, REM on XLEN-bit operands.
// Latency: fixed XLEN+1 edges from start to done for every op, including divide by zero.
// Backpressure: none; start is accepted only in IDLE and ignored otherwise. Optional macro MUL_DIV_SIGNED_EN enables signed mode.
module mul_div #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic            sgn,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result,
    output logic            busy,
    output logic            done
);

    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   hi_q, hi_d;      // product high half / partial remainder
    logic [XLEN-1:0]   lo_q, lo_d;      // multiplier then product low half / dividend then quotient
    logic [XLEN-1:0]   dv_q, dv_d;      // multiplicand or divisor magnitude
    logic [1:0]        op_q, op_d;
    logic              neg_a_q, neg_a_d;
    logic              neg_b_q, neg_b_d;
    logic              bz_q, bz_d;      // divisor was zero: quotient keeps its all-ones value
    logic [XLEN-1:0]   result_q, result_d;

    logic              neg_a_in, neg_b_in;
    logic [XLEN-1:0]   a_mag, b_mag;

`ifdef MUL_DIV_SIGNED_EN
    assign neg_a_in = sgn & a[XLEN-1];
    assign neg_b_in = sgn & b[XLEN-1];
`else
    logic unused_sgn;
    assign unused_sgn = sgn;
    assign neg_a_in   = 1'b0;
    assign neg_b_in   = 1'b0;
`endif

    // The core always works on magnitudes; signs are reapplied when the result is written.
    assign a_mag = neg_a_in ? -a : a;
    assign b_mag = neg_b_in ? -b : b;

    logic [XLEN:0]     add_sum;
    logic [XLEN:0]     r_sh;
    logic              ge;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;

    // One iteration of either datapath, plus the sign-corrected final values.
    always_comb begin
        add_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dv_q} : {(XLEN+1){1'b0}});
        r_sh     = {hi_q, lo_q[XLEN-1]};
        ge       = (r_sh >= {1'b0, dv_q});
        prod     = {hi_q, lo_q};
        prod_fix = (neg_a_q ^ neg_b_q) ? -prod : prod;
        quo_fix  = ((neg_a_q ^ neg_b_q) & ~bz_q) ? -lo_q : lo_q;
        rem_fix  = neg_a_q ? -hi_q : hi_q;
    end

    // Next-state and datapath control; everything holds unless a transition says otherwise.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dv_d     = dv_q;
        op_d     = op_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        bz_d     = bz_q;
        result_d = result_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    op_d    = op;
                    neg_a_d = neg_a_in;
                    neg_b_d = neg_b_in;
                    bz_d    = (b == '0);
                    hi_d    = '0;
                    // Multiplier and dividend both start in the low register.
                    lo_d    = op[1] ? a_mag : b_mag;
                    dv_d    = op[1] ? b_mag : a_mag;
                end
            end
            S_RUN: begin
                if (cnt_q == CW'(XLEN)) begin
                    // Extra finishing cycle keeps latency at XLEN+1 and applies signs.
                    state_d = S_DONE;
                    unique case (op_q)
                        2'b00:   result_d = prod_fix[XLEN-1:0];
                        2'b01:   result_d = prod_fix[2*XLEN-1:XLEN];
                        2'b10:   result_d = quo_fix;
                        default: result_d = rem_fix;
                    endcase
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (op_q[1]) begin
                        hi_d = ge ? (r_sh[XLEN-1:0] - dv_q) : r_sh[XLEN-1:0];
                        lo_d = {lo_q[XLEN-2:0], ge};
                    end else begin
                        hi_d = add_sum[XLEN:1];
                        lo_d = {add_sum[0], lo_q[XLEN-1:1]};
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            dv_q     <= '0;
            op_q     <= 2'b00;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            bz_q     <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            dv_q     <= dv_d;
            op_q     <= op_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            bz_q     <= bz_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;
    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);

endmodule

// File: tb/tb_mul_div.sv
// Bench for mul_div: arithmetic reference model plus directed vectors with literal expectations.
// Latency: model expects done exactly XLEN+1 edges after the accepted start.
// Backpressure: model ignores start whenever an operation is in flight.
module tb_mul_div;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst, start, sgn;
    logic [1:0]      op;
    logic [XLEN-1:0] a, b;
    logic [XLEN-1:0] result;
    logic            busy, done;

    int n_checks = 0;
    int n_errors = 0;

    mul_div #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .sgn    (sgn),
        .a      (a),
        .b      (b),
        .result (result),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference arithmetic straight from the op definitions.
    function automatic logic [31:0] ref_op(input logic [1:0] o, input logic s, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sp;
        logic [63:0]        up;
        logic               sm;
`ifdef MUL_DIV_SIGNED_EN
        sm = s;
`else
        sm = 1'b0 & s;
`endif
        if (!o[1]) begin
            if (sm) begin
                sp = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
                up = sp;
            end else begin
                up = {32'd0, x} * {32'd0, y};
            end
            return o[0] ? up[63:32] : up[31:0];
        end
        if (y == 32'd0) return o[0] ? x : 32'hFFFF_FFFF;
        if (sm) begin
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return o[0] ? 32'd0 : x;
            return o[0] ? 32'($signed(x) % $signed(y)) : 32'($signed(x) / $signed(y));
        end
        return o[0] ? (x % y) : (x / y);
    endfunction

    // Timing model: counts edges since the accepted start.
    bit              m_init = 0;
    bit              m_act  = 0;
    int              m_edges = 0;
    logic [XLEN-1:0] m_res, m_pend;

    always @(posedge clk) begin
        if (rst) begin
            m_act   = 0;
            m_edges = 0;
            m_res   = '0;
            m_init  = 1;
        end else if (m_act) begin
            m_edges++;
            if (m_edges == XLEN + 1) m_res = m_pend;
            if (m_edges == XLEN + 2) m_act = 0;
        end else if (start) begin
            m_act   = 1;
            m_edges = 0;
            m_pend  = ref_op(op, sgn, a, b);
        end
    end

    // Compare DUT against the model every cycle once reset has been seen.
    always @(negedge clk) begin
        if (m_init) begin
            chk("model_busy",   {31'd0, busy},   {31'd0, m_act});
            chk("model_done",   {31'd0, done},   {31'd0, (m_act && m_edges == XLEN + 1)});
            chk("model_result", result,          m_res);
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    // Launch at a negedge, count edges to done, check result and the following idle cycle.
    task automatic run_op(input string nm, input logic [1:0] o, input logic s,
                          input logic [31:0] x, input logic [31:0] y, input logic [31:0] exp);
        int n;
        wait_idle();
        op = o; sgn = s; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_latency"}, n, XLEN + 1);
        chk(nm, result, exp);
        @(negedge clk);
        chk({nm, "_busy_after"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int n, dones;
        rst = 1'b1; start = 1'b0; op = 2'b00; sgn = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_result", result, 32'd0);
        chk("reset_busy",   {31'd0, busy}, 32'd0);
        chk("reset_done",   {31'd0, done}, 32'd0);
        rst = 1'b0;

        run_op("mul_7x6",    2'b00, 1'b0, 32'd7,          32'd6,          32'd42);
        run_op("mulh_ff",    2'b01, 1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE);
        run_op("mul_ff",     2'b00, 1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001);
        run_op("div_100_7",  2'b10, 1'b0, 32'd100,        32'd7,          32'd14);
        run_op("rem_100_7",  2'b11, 1'b0, 32'd100,        32'd7,          32'd2);
        run_op("div_by_0",   2'b10, 1'b0, 32'd100,        32'd0,          32'hFFFF_FFFF);
        run_op("rem_by_0",   2'b11, 1'b0, 32'd5,          32'd0,          32'd5);
        run_op("mulh_small", 2'b01, 1'b0, 32'h0001_0000,  32'h0003_0000,  32'd3);
`ifdef MUL_DIV_SIGNED_EN
        run_op("sdiv_m7_2",  2'b10, 1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD);
        run_op("srem_m7_2",  2'b11, 1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF);
        run_op("sdiv_ovf",   2'b10, 1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000);
        run_op("srem_ovf",   2'b11, 1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0);
        run_op("smul_m3_5",  2'b00, 1'b1, 32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1);
        run_op("smulh_m3_5", 2'b01, 1'b1, 32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFFF);
        run_op("sdiv_m5_0",  2'b10, 1'b1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF);
        run_op("srem_m5_0",  2'b11, 1'b1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB);
`else
        run_op("udiv_sgn1",  2'b10, 1'b1, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC);
        run_op("urem_sgn1",  2'b11, 1'b1, 32'hFFFF_FFF9,  32'd2,          32'd1);
        run_op("umul_sgn1",  2'b00, 1'b1, 32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1);
        run_op("umulh_sgn1", 2'b01, 1'b1, 32'hFFFF_FFFD,  32'd5,          32'd4);
`endif

        // Operands latched at start; a start pulse mid-run must not queue.
        wait_idle();
        op = 2'b00; sgn = 1'b0; a = 32'd7; b = 32'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        a = 32'd123; b = 32'd456; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 6;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("latch_latency", n, XLEN + 1);
        chk("latch_result", result, 32'd42);
        // Start during the done cycle is ignored.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) begin
            chk("no_extra_op", {31'd0, busy}, 32'd0);
            @(negedge clk);
        end

        // Reset in the middle of an operation aborts it.
        op = 2'b10; a = 32'd100; b = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy",   {31'd0, busy}, 32'd0);
        chk("abort_done",   {31'd0, done}, 32'd0);
        chk("abort_result", result, 32'd0);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("abort_no_done", dones, 0);

        // Reset wins over start in the same cycle.
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("rst_over_start", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("rst_over_start2", {31'd0, busy}, 32'd0);

        // A final op after the abort still works.
        run_op("after_abort", 2'b00, 1'b0, 32'd1000, 32'd1000, 32'd1000000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
